// File: rtl/soc_system_pll_reset_ctrl.sv
// PLL reset sequencer and lock supervisor: pulses the PLL reset, qualifies lock, then releases sys_rst.
// Define SOC_SYSTEM_PLL_LOSS_CNT_EN to build the saturating lock_loss_cnt register (otherwise it reads 0).
module soc_system_pll_reset_ctrl #(
   parameter int RST_PULSE_CYCLES    = 50,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int LOCK_STABLE_CYCLES  = 1000,
   parameter int MAX_RETRIES         = 3
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       locked_in,
   input  logic       sw_restart,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_cnt,
   output logic [7:0] lock_loss_cnt
);

   localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
   localparam int CNT_W     = ($clog2(CNT_MAX) > 16) ? $clog2(CNT_MAX) : 16;

   localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_LAST   = 4'(MAX_RETRIES - 1);

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             cnt_clr;
   logic             retry_clr, retry_inc;
   logic             sync_p0, sync_p1;
   logic             locked_s;

   assign locked_s = sync_p1;

   always_ff @(posedge refclk) begin
      if (rst) begin
         state     <= S_RESET_PLL;
         cnt       <= '0;
         retry_cnt <= '0;
         sync_p0   <= 1'b0;
         sync_p1   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_clr ? '0 : cnt + 1'b1;
         sync_p0 <= locked_in;
         sync_p1 <= sync_p0;
         if (retry_clr)
            retry_cnt <= '0;
         else if (retry_inc)
            retry_cnt <= retry_cnt + 4'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      retry_clr = 1'b0;
      retry_inc = 1'b0;
      pll_rst   = 1'b1;
      sys_rst   = 1'b1;
      ready     = 1'b0;
      fault     = 1'b0;

      if (sw_restart) begin
         state_nxt = S_RESET_PLL;
         retry_clr = 1'b1;
      end else begin
         case (state)
            S_RESET_PLL: if (cnt == PULSE_LAST) state_nxt = S_WAIT_LOCK;
            // Lock takes precedence over a timeout landing on the same cycle.
            S_WAIT_LOCK: begin
               if (locked_s)
                  state_nxt = S_STABLE;
               else if (cnt == TIMEOUT_LAST) begin
                  if (retry_cnt == RETRY_LAST)
                     state_nxt = S_FAULT;
                  else begin
                     retry_inc = 1'b1;
                     state_nxt = S_RESET_PLL;
                  end
               end
            end
            S_STABLE: begin
               if (!locked_s)
                  state_nxt = S_WAIT_LOCK;
               else if (cnt == STABLE_LAST) begin
                  state_nxt = S_RUN;
                  retry_clr = 1'b1;
               end
            end
            S_RUN:   if (!locked_s) state_nxt = S_RESET_PLL;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_RESET_PLL;
         endcase
      end

      cnt_clr = sw_restart || (state_nxt != state);

      case (state)
         S_RESET_PLL: begin pll_rst = 1'b1; sys_rst = 1'b1; end
         S_WAIT_LOCK: begin pll_rst = 1'b0; sys_rst = 1'b1; end
         S_STABLE:    begin pll_rst = 1'b0; sys_rst = 1'b1; end
         S_RUN:       begin pll_rst = 1'b0; sys_rst = 1'b0; ready = 1'b1; end
         S_FAULT:     begin pll_rst = 1'b1; sys_rst = 1'b1; fault = 1'b1; end
         default:     begin pll_rst = 1'b1; sys_rst = 1'b1; end
      endcase
   end

`ifdef SOC_SYSTEM_PLL_LOSS_CNT_EN
   logic loss_inc;

   // A restart request outranks the loss event, so it is not counted.
   assign loss_inc = (state == S_RUN) && !locked_s && !sw_restart;

   always_ff @(posedge refclk) begin
      if (rst)
         lock_loss_cnt <= '0;
      else if (loss_inc && (lock_loss_cnt != 8'hFF))
         lock_loss_cnt <= lock_loss_cnt + 8'd1;
   end
`else
   assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_soc_system_pll_reset_ctrl.sv
// Scoreboard bench for soc_system_pll_reset_ctrl: expectations are queued by cycle number when
// stimulus is driven and compared on the falling edge of that cycle.
module tb_soc_system_pll_reset_ctrl;

   localparam int PU  = 5;
   localparam int TO  = 60;
   localparam int STB = 20;
   localparam int MR  = 3;
`ifdef SOC_SYSTEM_PLL_LOSS_CNT_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif

   localparam int SIG_OUT = 0, SIG_RETRY = 1, SIG_LOSS = 2;
   localparam int O_RESET = 4'b1100, O_WAIT = 4'b0100, O_RUN = 4'b0010, O_FAULT = 4'b1101;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       locked_in = 1'b0;
   logic       sw_restart = 1'b0;
   logic       pll_rst, sys_rst, ready, fault;
   logic [3:0] retry_cnt;
   logic [7:0] lock_loss_cnt;

   soc_system_pll_reset_ctrl #(
      .RST_PULSE_CYCLES   (PU),
      .LOCK_TIMEOUT_CYCLES(TO),
      .LOCK_STABLE_CYCLES (STB),
      .MAX_RETRIES        (MR)
   ) dut (
      .refclk       (refclk),
      .rst          (rst),
      .locked_in    (locked_in),
      .sw_restart   (sw_restart),
      .pll_rst      (pll_rst),
      .sys_rst      (sys_rst),
      .ready        (ready),
      .fault        (fault),
      .retry_cnt    (retry_cnt),
      .lock_loss_cnt(lock_loss_cnt)
   );

   always #5 refclk = ~refclk;

   typedef struct {
      int at;
      int sig;
      int val;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   loss_n = 0;

   always @(posedge refclk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic push(input int at, input int sig, input int val);
      exp_t e;
      e.at = at; e.sig = sig; e.val = val;
      sb.push_back(e);
   endtask

   function automatic int loss_exp();
      if (!LOSS_EN) return 0;
      return (loss_n > 255) ? 255 : loss_n;
   endfunction

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   always @(negedge refclk) begin
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         mon_e = sb.pop_front();
         if (mon_e.at < cyc)
            check("late", cyc, mon_e.at);
         else if (mon_e.sig == SIG_OUT)
            check("outs", int'({pll_rst, sys_rst, ready, fault}), mon_e.val);
         else if (mon_e.sig == SIG_RETRY)
            check("retry_cnt", int'(retry_cnt), mon_e.val);
         else
            check("lock_loss_cnt", int'(lock_loss_cnt), mon_e.val);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r, l, d, s, g, p0, f, p1, m;

      // Bring-up: reset release, lock arrives mid-wait.
      repeat (3) tick();
      r = cyc;
      rst = 1'b0;
      l = r + 30;
      push(r, SIG_OUT, O_RESET);
      push(r, SIG_RETRY, 0);
      push(r, SIG_LOSS, 0);
      push(r + PU - 1, SIG_OUT, O_RESET);
      push(r + PU, SIG_OUT, O_WAIT);
      wait_until(l);
      locked_in = 1'b1;
      push(l + 2, SIG_OUT, O_WAIT);
      push(l + STB + 2, SIG_OUT, O_WAIT);
      push(l + STB + 3, SIG_OUT, O_RUN);
      push(l + STB + 3, SIG_RETRY, 0);
      wait_until(l + STB + 5);

      // One-cycle lock drop in RUN.
      d = cyc;
      locked_in = 1'b0;
      tick();
      locked_in = 1'b1;
      loss_n++;
      push(d + 2, SIG_OUT, O_RUN);
      push(d + 3, SIG_OUT, O_RESET);
      push(d + 3, SIG_LOSS, loss_exp());
      push(d + 3 + PU, SIG_OUT, O_WAIT);
      push(d + PU + 3 + STB, SIG_OUT, O_WAIT);
      push(d + PU + 4 + STB, SIG_OUT, O_RUN);
      wait_until(d + PU + 6 + STB);

      // Glitch inside STABLE restarts the qualification window.
      s = cyc;
      sw_restart = 1'b1;
      tick();
      sw_restart = 1'b0;
      push(s + 1, SIG_OUT, O_RESET);
      push(s + 1, SIG_RETRY, 0);
      push(s + PU + 2, SIG_OUT, O_WAIT);
      g = s + PU + 12;
      wait_until(g);
      locked_in = 1'b0;
      tick();
      locked_in = 1'b1;
      push(g + 2, SIG_OUT, O_WAIT);
      push(s + PU + 2 + STB, SIG_OUT, O_WAIT);
      push(g + 3 + STB, SIG_OUT, O_WAIT);
      push(g + 4 + STB, SIG_OUT, O_RUN);
      push(g + 4 + STB, SIG_LOSS, loss_exp());
      wait_until(g + 6 + STB);

      // Lock never comes back: retries exhaust into FAULT.
      s = cyc;
      sw_restart = 1'b1;
      locked_in = 1'b0;
      p0 = s + 1;
      f = p0 + 3 * PU + 3 * TO;
      push(p0, SIG_OUT, O_RESET);
      push(p0, SIG_RETRY, 0);
      push(p0 + PU, SIG_OUT, O_WAIT);
      push(p0 + PU + TO - 1, SIG_OUT, O_WAIT);
      push(p0 + PU + TO, SIG_OUT, O_RESET);
      push(p0 + PU + TO, SIG_RETRY, 1);
      push(p0 + 2 * PU + TO, SIG_OUT, O_WAIT);
      push(p0 + 2 * PU + 2 * TO, SIG_OUT, O_RESET);
      push(p0 + 2 * PU + 2 * TO, SIG_RETRY, 2);
      push(f - 1, SIG_OUT, O_WAIT);
      push(f, SIG_OUT, O_FAULT);
      push(f, SIG_RETRY, 2);
      push(f + 10, SIG_OUT, O_FAULT);
      tick();
      sw_restart = 1'b0;
      wait_until(f + 10);
      sw_restart = 1'b1;
      p1 = f + 11;
      push(p1, SIG_OUT, O_RESET);
      push(p1, SIG_RETRY, 0);
      tick();
      sw_restart = 1'b0;

      // Lock arriving on the timeout cycle wins.
      wait_until(p1 + PU + TO - 3);
      locked_in = 1'b1;
      push(p1 + PU + TO - 1, SIG_OUT, O_WAIT);
      push(p1 + PU + TO, SIG_OUT, O_WAIT);
      push(p1 + PU + TO, SIG_RETRY, 0);
      push(p1 + PU + TO + STB - 1, SIG_OUT, O_WAIT);
      push(p1 + PU + TO + STB, SIG_OUT, O_RUN);
      wait_until(p1 + PU + TO + STB + 2);

      // rst and sw_restart together mid-STABLE.
      s = cyc;
      sw_restart = 1'b1;
      tick();
      sw_restart = 1'b0;
      m = s + PU + 7;
      push(s + PU + 2, SIG_OUT, O_WAIT);
      wait_until(m);
      rst = 1'b1;
      sw_restart = 1'b1;
      loss_n = 0;
      push(m + 1, SIG_OUT, O_RESET);
      push(m + 1, SIG_RETRY, 0);
      push(m + 1, SIG_LOSS, 0);
      tick();
      tick();
      rst = 1'b0;
      sw_restart = 1'b0;
      r = cyc;
      push(r, SIG_LOSS, 0);
      push(r + PU - 1, SIG_OUT, O_RESET);
      push(r + PU, SIG_OUT, O_WAIT);
      push(r + PU + STB, SIG_OUT, O_WAIT);
      push(r + PU + 1 + STB, SIG_OUT, O_RUN);
      wait_until(r + PU + STB + 3);

      // Repeated lock losses drive the loss counter to saturation.
      for (int i = 0; i < 300; i++) begin
         d = cyc;
         locked_in = 1'b0;
         tick();
         locked_in = 1'b1;
         loss_n++;
         push(d + PU + 4 + STB, SIG_OUT, O_RUN);
         wait_until(d + PU + 5 + STB);
         if (i == 4 || i == 254 || i == 299)
            push(cyc, SIG_LOSS, loss_exp());
      end

      repeat (3) tick();
      check("drain", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
